// File: rtl/ahci_dma_pkg.sv
// Shared constants and FSM encoding for the AHCI DMA AXI address-phase generator.
package ahci_dma_pkg;

   localparam int unsigned BEAT_BYTES     = 8;
   localparam int unsigned BEAT_SHIFT     = $clog2(BEAT_BYTES);
   localparam int unsigned PAGE_BEATS     = 512;
   localparam int unsigned PAGE_OFS_WIDTH = $clog2(PAGE_BEATS);
   localparam int unsigned AXI_LEN_WIDTH  = 4;
   localparam int unsigned AXI_ID_WIDTH   = 6;
   localparam int unsigned CREDIT_WIDTH   = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_NEXT  = 3'd3,
      ST_DRAIN = 3'd4
   } dma_state_e;

endpackage

// File: rtl/ahci_dma_credit_cnt.sv
// Saturating up/down occupancy counter with full/empty flags.
// Simultaneous inc and dec leave the count unchanged.
module ahci_dma_credit_cnt #(
   parameter int unsigned MAX_COUNT = 8,
   parameter int unsigned WIDTH     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             full_c,
   output logic             empty_c
);

   logic [WIDTH-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (inc && !dec && (count != WIDTH'(MAX_COUNT))) begin
         count_nxt = count + WIDTH'(1);
      end else if (dec && !inc && (count != '0)) begin
         count_nxt = count - WIDTH'(1);
      end
   end

   assign full_c  = (count == WIDTH'(MAX_COUNT));
   assign empty_c = (count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   // A completion with nothing outstanding is ignored but flagged in simulation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(dec && !inc && empty_c))
            else $error("ahci_dma_credit_cnt: completion with no credit outstanding");
      end
   end

endmodule

// File: rtl/ahci_dma_burst_gen.sv
// AXI address-phase generator: splits DMA segments into bursts that never cross a
// 4 KiB page, limited by an outstanding-burst credit window, with abort/drain.
module ahci_dma_burst_gen
   import ahci_dma_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned LEN_WIDTH       = 19,
   parameter int unsigned MAX_BURST       = 16,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned AXI_ID          = 0
) (
   input  logic                             hclk,
   input  logic                             hrst,
   input  logic [ADDR_WIDTH-BEAT_SHIFT-1:0] seg_addr,
   input  logic [LEN_WIDTH-1:0]             seg_len,
   input  logic                             seg_last,
   input  logic                             seg_valid,
   output logic                             seg_ready,
   input  logic                             abort,
   output logic [ADDR_WIDTH-1:0]            a_addr,
   output logic [AXI_LEN_WIDTH-1:0]         a_len,
   output logic [AXI_ID_WIDTH-1:0]          a_id,
   output logic                             a_valid,
   input  logic                             a_ready,
   input  logic                             burst_done,
   output logic [CREDIT_WIDTH-1:0]          outstanding,
   output logic                             busy,
   output logic                             cmd_done,
   output logic                             cmd_aborted
);

   localparam int unsigned BA_W   = ADDR_WIDTH - BEAT_SHIFT;
   localparam int unsigned BLEN_W = $clog2(MAX_BURST + 1);
   localparam int unsigned CAP_W  = PAGE_OFS_WIDTH + 2;
   localparam int unsigned CMP_W  = (LEN_WIDTH > CAP_W) ? LEN_WIDTH : CAP_W;

   dma_state_e           state;
   logic [BA_W-1:0]      cur_addr;
   logic [LEN_WIDTH-1:0] rem;
   logic                 last_seg;
   logic [BLEN_W-1:0]    blen;
   logic                 abort_pend;

   logic                 hs_c;
   logic                 full_c;
   logic                 empty_c;
   logic [CAP_W-1:0]     page_left_c;
   logic [CAP_W-1:0]     cap_c;
   logic [BLEN_W-1:0]    blen_c;
   logic [LEN_WIDTH-1:0] rem_after_c;

   assign a_id = AXI_ID_WIDTH'(AXI_ID);

   // Burst length: remaining beats clipped to MAX_BURST and to the end of the page.
   always_comb begin
      hs_c        = a_valid & a_ready;
      page_left_c = CAP_W'(PAGE_BEATS) - CAP_W'(cur_addr[PAGE_OFS_WIDTH-1:0]);
      cap_c       = (page_left_c < CAP_W'(MAX_BURST)) ? page_left_c : CAP_W'(MAX_BURST);
      blen_c      = (CMP_W'(rem) < CMP_W'(cap_c)) ? BLEN_W'(rem) : BLEN_W'(cap_c);
      rem_after_c = rem - LEN_WIDTH'(blen);
   end

   ahci_dma_credit_cnt #(
      .MAX_COUNT (MAX_OUTSTANDING),
      .WIDTH     (CREDIT_WIDTH)
   ) u_credit (
      .clk     (hclk),
      .rst     (hrst),
      .inc     (hs_c),
      .dec     (burst_done),
      .count   (outstanding),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   always_ff @(posedge hclk) begin
      if (hrst) begin
         state       <= ST_IDLE;
         cur_addr    <= '0;
         rem         <= '0;
         last_seg    <= 1'b0;
         blen        <= '0;
         abort_pend  <= 1'b0;
         seg_ready   <= 1'b0;
         a_addr      <= '0;
         a_len       <= '0;
         a_valid     <= 1'b0;
         busy        <= 1'b0;
         cmd_done    <= 1'b0;
         cmd_aborted <= 1'b0;
      end else begin
         cmd_done <= 1'b0;
         if (abort && (state != ST_IDLE)) begin
            cmd_aborted <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               seg_ready <= 1'b1;
               if (seg_valid && seg_ready) begin
                  cur_addr    <= seg_addr;
                  rem         <= seg_len;
                  last_seg    <= seg_last;
                  busy        <= 1'b1;
                  cmd_aborted <= 1'b0;
                  seg_ready   <= 1'b0;
                  state       <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (abort) begin
                  state <= ST_DRAIN;
               end else if (rem == '0) begin
                  seg_ready <= !last_seg;
                  state     <= ST_NEXT;
               end else begin
                  blen    <= blen_c;
                  a_addr  <= {cur_addr, {BEAT_SHIFT{1'b0}}};
                  a_len   <= AXI_LEN_WIDTH'(blen_c - BLEN_W'(1));
                  a_valid <= !full_c;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (hs_c) begin
                  a_valid  <= 1'b0;
                  cur_addr <= cur_addr + BA_W'(blen);
                  rem      <= rem_after_c;
                  if (abort || abort_pend) begin
                     abort_pend <= 1'b0;
                     state      <= ST_DRAIN;
                  end else if (rem_after_c != '0) begin
                     state <= ST_CALC;
                  end else begin
                     seg_ready <= !last_seg;
                     state     <= ST_NEXT;
                  end
               end else if (a_valid) begin
                  // An offered address must complete before the abort takes effect.
                  if (abort) begin
                     abort_pend <= 1'b1;
                  end
               end else if (abort) begin
                  state <= ST_DRAIN;
               end else begin
                  a_valid <= !full_c;
               end
            end
            ST_NEXT: begin
               // A segment offered in the abort cycle belongs to the discarded command.
               if (abort) begin
                  seg_ready <= 1'b0;
                  state     <= ST_DRAIN;
               end else if (last_seg) begin
                  seg_ready <= 1'b0;
                  state     <= ST_DRAIN;
               end else if (seg_valid && seg_ready) begin
                  cur_addr  <= seg_addr;
                  rem       <= seg_len;
                  last_seg  <= seg_last;
                  seg_ready <= 1'b0;
                  state     <= ST_CALC;
               end
            end
            ST_DRAIN: begin
               seg_ready <= 1'b0;
               if (empty_c) begin
                  cmd_done  <= 1'b1;
                  busy      <= 1'b0;
                  seg_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahci_dma_burst_gen.sv
// Self-checking bench for ahci_dma_burst_gen: default instance plus a 2-credit instance.
module tb_ahci_dma_burst_gen;

   logic        hclk;
   logic        hrst;
   logic [28:0] seg_addr;
   logic [18:0] seg_len;
   logic        seg_last, seg_valid, seg_valid2, abort;
   logic        seg_ready, seg_ready2;
   logic [31:0] a_addr, a_addr2;
   logic [3:0]  a_len, a_len2;
   logic [5:0]  a_id, a_id2;
   logic        a_valid, a_valid2, a_ready, a_ready2, burst_done, burst_done2;
   logic [3:0]  outstanding, outstanding2;
   logic        busy, busy2, cmd_done, cmd_done2, cmd_aborted, cmd_aborted2;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  len;
   } burst_t;

   burst_t exp_q[$];
   int     due_q[$];
   int     hs_cyc_q[$];
   int     tests = 0;
   int     fails = 0;
   int     cyc = 0;
   int     hs_cnt = 0;
   int     hs2 = 0;
   int     done_cnt = 0;
   int     done2 = 0;
   logic   done_aborted = 1'b0;
   logic   done_aborted2 = 1'b0;
   logic   auto_done = 1'b1;

   ahci_dma_burst_gen u_dut (
      .hclk (hclk), .hrst (hrst),
      .seg_addr (seg_addr), .seg_len (seg_len), .seg_last (seg_last),
      .seg_valid (seg_valid), .seg_ready (seg_ready), .abort (abort),
      .a_addr (a_addr), .a_len (a_len), .a_id (a_id), .a_valid (a_valid), .a_ready (a_ready),
      .burst_done (burst_done), .outstanding (outstanding), .busy (busy),
      .cmd_done (cmd_done), .cmd_aborted (cmd_aborted)
   );

   ahci_dma_burst_gen #(.MAX_OUTSTANDING (2)) u_dut2 (
      .hclk (hclk), .hrst (hrst),
      .seg_addr (seg_addr), .seg_len (seg_len), .seg_last (seg_last),
      .seg_valid (seg_valid2), .seg_ready (seg_ready2), .abort (abort),
      .a_addr (a_addr2), .a_len (a_len2), .a_id (a_id2), .a_valid (a_valid2), .a_ready (a_ready2),
      .burst_done (burst_done2), .outstanding (outstanding2), .busy (busy2),
      .cmd_done (cmd_done2), .cmd_aborted (cmd_aborted2)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   initial forever begin
      @(posedge hclk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   // Bursts: scoreboard pop on every address handshake; completions scheduled 4 cycles out.
   initial forever begin
      @(negedge hclk);
      if (a_valid && a_ready) begin
         burst_t e;
         int     end_ofs;
         check("burst_expected", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("burst_addr", 64'(a_addr), 64'(e.addr));
            check("burst_len", 64'(a_len), 64'(e.len));
         end
         end_ofs = int'(a_addr[11:0]) + (int'(a_len) + 1) * 8;
         check("page_cross", 64'(end_ofs <= 4096), 1);
         check("burst_id", 64'(a_id), 0);
         hs_cnt++;
         hs_cyc_q.push_back(cyc);
         if (auto_done) due_q.push_back(4);
      end
      if (cmd_done) begin
         done_cnt++;
         done_aborted = cmd_aborted;
      end
      if (a_valid2 && a_ready2) begin
         check("d2_addr", 64'(a_addr2), 64'(hs2) * 64'h80);
         check("d2_len", 64'(a_len2), 15);
         check("d2_id", 64'(a_id2), 0);
         hs2++;
      end
      if (cmd_done2) begin
         done2++;
         done_aborted2 = cmd_aborted2;
      end
   end

   initial begin
      burst_done = 1'b0;
      forever begin
         @(posedge hclk);
         #1;
         burst_done = 1'b0;
         foreach (due_q[i]) due_q[i] = due_q[i] - 1;
         if (due_q.size() != 0 && due_q[0] <= 0) begin
            void'(due_q.pop_front());
            burst_done = 1'b1;
         end
      end
   end

   task automatic send_seg(input int which, input logic [28:0] addr, input logic [18:0] len,
                           input logic last, output int acc);
      seg_addr = addr;
      seg_len  = len;
      seg_last = last;
      if (which == 0) seg_valid = 1'b1;
      else seg_valid2 = 1'b1;
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge hclk);
         if ((which == 0) ? seg_ready : seg_ready2) begin
            acc = cyc;
            break;
         end
      end
      check("seg_accept", 64'(acc >= 0), 1);
      @(posedge hclk);
      #1;
      seg_valid  = 1'b0;
      seg_valid2 = 1'b0;
   endtask

   task automatic wait_valid(input int which, output int vcyc);
      vcyc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge hclk);
         if ((which == 0) ? a_valid : a_valid2) begin
            vcyc = cyc;
            break;
         end
      end
      check("a_valid_seen", 64'(vcyc >= 0), 1);
   endtask

   task automatic wait_done(input int base, input int budget);
      int seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge hclk);
         if (done_cnt > base) begin
            seen = 1;
            break;
         end
      end
      check("cmd_done_seen", 64'(seen), 1);
   endtask

   initial begin
      int acc, v, seen;
      hrst = 1'b1; seg_addr = '0; seg_len = '0; seg_last = 1'b0;
      seg_valid = 1'b0; seg_valid2 = 1'b0; abort = 1'b0;
      a_ready = 1'b1; a_ready2 = 1'b1; burst_done2 = 1'b0;

      // Reset state
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      check("rst_seg_ready", 64'(seg_ready), 0);
      check("rst_a_valid", 64'(a_valid), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_outstanding", 64'(outstanding), 0);
      check("rst_cmd_done", 64'(cmd_done), 0);
      check("rst_cmd_aborted", 64'(cmd_aborted), 0);
      check("rst_a_addr", 64'(a_addr), 0);
      check("rst_d2_outstanding", 64'(outstanding2), 0);
      step();
      hrst = 1'b0;
      @(negedge hclk);
      @(negedge hclk);
      check("idle_seg_ready", 64'(seg_ready), 1);

      // 40 beats from byte 0x100: 16+16+8
      step();
      hs_cyc_q.delete();
      exp_q.push_back('{addr: 32'h100, len: 4'd15});
      exp_q.push_back('{addr: 32'h180, len: 4'd15});
      exp_q.push_back('{addr: 32'h200, len: 4'd7});
      send_seg(0, 29'h20, 19'd40, 1'b1, acc);
      wait_valid(0, v);
      check("lat_accept_to_valid", 64'(v - acc), 2);
      wait_done(0, 100);
      check("t1_burst_gap", 64'(hs_cyc_q[1] - hs_cyc_q[0]), 2);
      check("t1_done_cnt", 64'(done_cnt), 1);
      check("t1_aborted", 64'(done_aborted), 0);
      check("t1_hs_cnt", 64'(hs_cnt), 3);
      check("t1_q_empty", 64'(exp_q.size()), 0);
      check("t1_outstanding", 64'(outstanding), 0);
      check("t1_busy", 64'(busy), 0);

      // Page split: beat 0x1FA, 20 beats -> 6 then 14
      step();
      exp_q.push_back('{addr: 32'hFD0, len: 4'd5});
      exp_q.push_back('{addr: 32'h1000, len: 4'd13});
      send_seg(0, 29'h1FA, 19'd20, 1'b1, acc);
      wait_done(1, 100);
      check("t2_hs_cnt", 64'(hs_cnt), 5);
      check("t2_q_empty", 64'(exp_q.size()), 0);

      // Credit window of 2 on the second instance
      step();
      send_seg(1, 29'h0, 19'd64, 1'b1, acc);
      repeat (20) @(negedge hclk);
      check("t3_hs_two", 64'(hs2), 2);
      check("t3_valid_low", 64'(a_valid2), 0);
      check("t3_outstanding_full", 64'(outstanding2), 2);
      step();
      a_ready2 = 1'b0;
      burst_done2 = 1'b1;
      step();
      burst_done2 = 1'b0;
      wait_valid(1, v);
      check("t3_outstanding_one", 64'(outstanding2), 1);
      step();
      a_ready2 = 1'b1;
      burst_done2 = 1'b1;
      step();
      a_ready2 = 1'b0;
      burst_done2 = 1'b0;
      @(negedge hclk);
      check("t3_hs_three", 64'(hs2), 3);
      check("t3_same_cycle_unchanged", 64'(outstanding2), 1);
      step();
      a_ready2 = 1'b1;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         burst_done2 = (outstanding2 != 4'd0);
         step();
         if (done2 > 0) begin
            seen = 1;
            break;
         end
      end
      burst_done2 = 1'b0;
      check("t3_done_seen", 64'(seen), 1);
      check("t3_hs_total", 64'(hs2), 4);
      check("t3_aborted", 64'(done_aborted2), 0);
      check("t3_busy", 64'(busy2), 0);

      // len=3 not last, then len=0 last
      step();
      exp_q.push_back('{addr: 32'h800, len: 4'd2});
      send_seg(0, 29'h100, 19'd3, 1'b0, acc);
      send_seg(0, 29'h3F0, 19'd0, 1'b1, acc);
      wait_done(2, 100);
      check("t4_aborted", 64'(done_aborted), 0);
      check("t4_hs_cnt", 64'(hs_cnt), 6);
      check("t4_q_empty", 64'(exp_q.size()), 0);

      // Abort while the address is stalled
      step();
      a_ready = 1'b0;
      exp_q.push_back('{addr: 32'h0, len: 4'd15});
      send_seg(0, 29'h0, 19'd64, 1'b1, acc);
      wait_valid(0, v);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge hclk);
         check("t5_valid_held", 64'(a_valid), 1);
         check("t5_addr_held", 64'(a_addr), 0);
      end
      check("t5_seg_ready", 64'(seg_ready), 0);
      check("t5_aborted_set", 64'(cmd_aborted), 1);
      step();
      a_ready = 1'b1;
      wait_done(3, 100);
      check("t5_done_aborted", 64'(done_aborted), 1);
      check("t5_hs_cnt", 64'(hs_cnt), 7);
      repeat (3) @(negedge hclk);
      check("t5_aborted_held", 64'(cmd_aborted), 1);
      check("t5_no_more_bursts", 64'(hs_cnt), 7);
      check("t5_busy", 64'(busy), 0);

      // Reset with 3 bursts outstanding
      step();
      auto_done = 1'b0;
      exp_q.push_back('{addr: 32'h0, len: 4'd15});
      exp_q.push_back('{addr: 32'h80, len: 4'd15});
      exp_q.push_back('{addr: 32'h100, len: 4'd15});
      send_seg(0, 29'h0, 19'd48, 1'b1, acc);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge hclk);
         if (hs_cnt == 10) begin
            seen = 1;
            break;
         end
      end
      check("t6_three_issued", 64'(seen), 1);
      @(negedge hclk);
      check("t6_outstanding_pre", 64'(outstanding), 3);
      check("t6_busy_pre", 64'(busy), 1);
      step();
      hrst = 1'b1;
      step();
      hrst = 1'b0;
      @(negedge hclk);
      check("t6_outstanding", 64'(outstanding), 0);
      check("t6_busy", 64'(busy), 0);
      check("t6_a_valid", 64'(a_valid), 0);
      check("t6_seg_ready", 64'(seg_ready), 0);
      check("t6_cmd_done", 64'(cmd_done), 0);
      repeat (8) @(negedge hclk);
      check("t6_no_done", 64'(done_cnt), 4);
      step();
      auto_done = 1'b1;
      exp_q.push_back('{addr: 32'h80, len: 4'd7});
      send_seg(0, 29'h10, 19'd8, 1'b1, acc);
      check("t6_aborted_clear", 64'(cmd_aborted), 0);
      wait_done(4, 100);
      check("t6_fresh_aborted", 64'(done_aborted), 0);
      check("t6_q_empty", 64'(exp_q.size()), 0);
      check("t6_outstanding_end", 64'(outstanding), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
